mux4_rr_arb: RTL and testbench

Round-robin arbiter and sequencer for the 4->1 single-bit `mux4` datapath. Four requesters compete for the shared output `z`. The block grants one requester at a time, drives the `mux4` select, and presents a valid/ready handshake to the consumer. A grant lasts for up to `BURST` accepted beats, then rotates fairly.

---
 rtl/mux4_rr_arb.sv | 128 ++++++++++++
 tb/tb_mux4_rr_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter/sequencer for a 4->1 single-bit mux with valid/ready output.
// Define MUX4_RR_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.

module mux4 (
  input  logic [3:0] d_i,
  input  logic [1:0] sel_i,
  output logic       z_o
);
  assign z_o = d_i[sel_i];
endmodule

module mux4_rr_arb #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  input  logic       ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       z
);

  localparam int unsigned CntW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BURST - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [1:0]      own_q, own_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      scan_base;
  logic [3:0]      req_rest;
  logic            xfer, burst_done, rel, grant;

  // First set bit of r, scanning base, base+1, base+2, base+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

`ifdef MUX4_RR_ARB_FIXED_PRIO_EN
  assign scan_base = 2'd0;
`else
  logic [1:0] last_q, last_d;
  assign scan_base = last_q + 2'd1;
`endif

  assign req_rest   = req & ~(4'b0001 << own_q);
  assign valid      = (state_q == StBusy) && req[own_q];
  assign xfer       = valid && ready;
  assign burst_done = xfer && (cnt_q == CntMax);
  assign rel        = !req[own_q] || burst_done;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          state_d = StBusy;
          own_d   = pick(req, scan_base);
          cnt_d   = '0;
          grant   = 1'b1;
        end
      end
      StBusy: begin
        if (rel) begin
          cnt_d = '0;
          if (req_rest != 4'b0000) begin
            own_d = pick(req_rest, scan_base);
            grant = 1'b1;
          end else if (burst_done && req[own_q]) begin
            // Sole requester hit the burst limit: re-grant without a bubble.
            grant = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifndef MUX4_RR_ARB_FIXED_PRIO_EN
  assign last_d = grant ? own_d : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd3;
    else        last_q <= last_d;
  end
`else
  logic unused_grant;
  assign unused_grant = grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      own_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = (state_q == StBusy) ? (4'b0001 << own_q) : 4'b0000;
  assign sel = own_q;

  mux4 u_mux4 (
    .d_i   (d),
    .sel_i (own_q),
    .z_o   (z)
  );

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Directed bench for mux4_rr_arb (default round-robin build, BURST=4).

module tb_mux4_rr_arb;

  logic       clk, rst_n, ready, valid, z;
  logic [3:0] req, d, gnt;
  logic [1:0] sel;
  int         errors = 0;
  int         checks = 0;

  mux4_rr_arb #(.BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .ready (ready),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] o;
    rst_n = 1'b0; req = 4'b1111; d = 4'b1010; ready = 1'b1;
    #1;
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_sel", 8'(sel), 8'h0);
    chk("rst_z0", 8'(z), 8'h0);
    d = 4'b0001; #1;
    chk("rst_z1", 8'(z), 8'h1);

    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("first_gnt", 8'(gnt), 8'h1);
    chk("first_sel", 8'(sel), 8'h0);
    chk("first_valid", 8'(valid), 8'h1);
    chk("first_z1", 8'(z), 8'h1);
    d = 4'b0000; #1;
    chk("first_z0", 8'(z), 8'h0);

    // Full rotation: 0,1,2,3,0 for 4 beats each, no gaps.
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        o = 2'(g % 4);
        chk("rot_gnt", 8'(gnt), 8'(4'b0001 << o));
        chk("rot_sel", 8'(sel), 8'(o));
        chk("rot_valid", 8'(valid), 8'h1);
        tick();
      end
    end

    // Early release: owner 1 drops, 2 takes one beat then drops with req=1001.
    req = 4'b0100; #1;
    chk("er_drop_valid", 8'(valid), 8'h0);
    chk("er_drop_gnt", 8'(gnt), 8'h2);
    tick();
    chk("er_own2_gnt", 8'(gnt), 8'h4);
    chk("er_own2_valid", 8'(valid), 8'h1);
    tick();
    req = 4'b1001; #1;
    chk("er_own2_drop", 8'(valid), 8'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("er_own3_gnt", 8'(gnt), 8'h8);
      chk("er_own3_sel", 8'(sel), 8'h3);
      d = (b % 2 == 0) ? 4'b1000 : 4'b0111; #1;
      chk("er_own3_z", 8'(z), (b % 2 == 0) ? 8'h1 : 8'h0);
      tick();
    end
    chk("er_next_gnt", 8'(gnt), 8'h1);

    // Sole requester 1 across burst re-grants.
    req = 4'b0010; #1;
    chk("sole_drop_valid", 8'(valid), 8'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("sole_gnt", 8'(gnt), 8'h2);
      chk("sole_valid", 8'(valid), 8'h1);
      tick();
    end

    // Stall at cnt=2: grant holds, then 2 remaining beats before rotation.
    req = 4'b0011; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_gnt", 8'(gnt), 8'h2);
      chk("stall_sel", 8'(sel), 8'h1);
      chk("stall_valid", 8'(valid), 8'h1);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("stall_rest_gnt", 8'(gnt), 8'h2);
      tick();
    end
    chk("stall_rot_gnt", 8'(gnt), 8'h1);

    // Idle, 1-cycle latency, sel hold, round-robin resume.
    req = 4'b0000; #1;
    chk("idle_drop_valid", 8'(valid), 8'h0);
    tick();
    chk("idle_gnt", 8'(gnt), 8'h0);
    chk("idle_valid", 8'(valid), 8'h0);
    req = 4'b0100;
    tick();
    chk("lat_gnt", 8'(gnt), 8'h4);
    chk("lat_sel", 8'(sel), 8'h2);
    chk("lat_valid", 8'(valid), 8'h1);
    req = 4'b0000;
    tick();
    chk("idle2_gnt", 8'(gnt), 8'h0);
    chk("idle2_sel_hold", 8'(sel), 8'h2);
    req = 4'b1111;
    tick();
    chk("rr_after_idle", 8'(gnt), 8'h8);

    // Asynchronous reset mid-grant.
    #2; rst_n = 1'b0; #1;
    chk("arst_gnt", 8'(gnt), 8'h0);
    chk("arst_valid", 8'(valid), 8'h0);
    chk("arst_sel", 8'(sel), 8'h0);
    chk("arst_z", 8'(z), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
